tcm_dual_controller: RTL and testbench

- Tightly-coupled memory controller serving two bus masters from one single-port word array.
  - Port A: instruction fetch, read-only.
  - Port B: data load/store.
- Round-robin arbitration and alignment/permission fault detection.
- Optional output pipeline register, selected by parameter, for timing closure on larger arrays.
- Sits between the core's fetch/LSU bus interfaces and the on-chip RAM.

---
 rtl/tcm_dual_controller_pkg.sv | 45 ++++
 rtl/tcm_rr_arbiter.sv | 30 +++
 rtl/tcm_dual_controller.sv | 154 +++++++++++++++
 tb/tb_tcm_dual_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_dual_controller_pkg.sv
// Shared constants and helpers for the dual-port TCM controller: bus access
// size encodings, port indices and the per-access decode functions.
package tcm_dual_controller_pkg;

  localparam int BUS_ACC_1B  = 0;
  localparam int BUS_ACC_2B  = 1;
  localparam int BUS_ACC_4B  = 2;
  localparam int BUS_ACC_CNT = 3;
  localparam int BUS_ACC_W   = $clog2(BUS_ACC_CNT);

  localparam int TCM_PORT_A = 0;
  localparam int TCM_PORT_B = 1;

  // Per-slot bookkeeping carried from the grant cycle into the response path.
  typedef struct packed {
    logic                 valid;
    logic                 port;
    logic                 fault;
    logic                 wr;
    logic [BUS_ACC_W-1:0] acc;
    logic [1:0]           lane;
  } tcm_slot_t;

  // Any code outside the three defined sizes is treated as a fault.
  function automatic logic tcm_misaligned(input logic [BUS_ACC_W-1:0] acc,
                                          input logic [1:0]           lo);
    logic bad;
    bad = 1'b0;
    if (acc == BUS_ACC_W'(BUS_ACC_2B))      bad = lo[0];
    else if (acc == BUS_ACC_W'(BUS_ACC_4B)) bad = |lo;
    else if (acc != BUS_ACC_W'(BUS_ACC_1B)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] tcm_byte_en(input logic [BUS_ACC_W-1:0] acc,
                                             input logic [1:0]           lo);
    logic [3:0] be;
    be = 4'b0000;
    if (acc == BUS_ACC_W'(BUS_ACC_1B))      be = 4'b0001 << lo;
    else if (acc == BUS_ACC_W'(BUS_ACC_2B)) be = lo[1] ? 4'b1100 : 4'b0011;
    else if (acc == BUS_ACC_W'(BUS_ACC_4B)) be = 4'b1111;
    return be;
  endfunction

endpackage

// File: rtl/tcm_rr_arbiter.sv
// Two-requester round-robin arbiter with a per-requester mask; grant is
// combinational, the preferred-next pointer is registered.
module tcm_rr_arbiter #(
  parameter bit PRIO_B_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);

  logic       prio_q, prio_d;
  logic [1:0] elig;

  always_comb begin
    elig   = req_i & ~mask_i;
    gnt_o  = elig;
    if (elig == 2'b11) gnt_o = prio_q ? 2'b10 : 2'b01;
    prio_d = prio_q;
    if (gnt_o[1])      prio_d = 1'b0;
    else if (gnt_o[0]) prio_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prio_q <= PRIO_B_FIRST;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/tcm_dual_controller.sv
// Tightly-coupled memory controller: fetch port A and load/store port B share
// one single-port word array, arbitrated round-robin, with fault detection.
module tcm_dual_controller
  import tcm_dual_controller_pkg::*;
#(
  parameter int BYTE_ADDR_WIDTH = 12,
  parameter bit PIPE_OUT        = 1'b0,
  parameter bit PRIO_B_FIRST    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       a_req,
  output logic                       a_resp,
  input  logic [BYTE_ADDR_WIDTH-1:0] a_addr,
  input  logic                       a_wr_b,
  input  logic [BUS_ACC_W-1:0]       a_acc,
  output logic [31:0]                a_rdata,
  output logic                       a_fault,
  input  logic                       b_req,
  output logic                       b_resp,
  input  logic [BYTE_ADDR_WIDTH-1:0] b_addr,
  input  logic                       b_wr_b,
  input  logic [BUS_ACC_W-1:0]       b_acc,
  input  logic [31:0]                b_wdata,
  output logic [31:0]                b_rdata,
  output logic                       b_fault
);

  localparam int WORD_AW = BYTE_ADDR_WIDTH - 2;
  localparam int DEPTH   = 1 << WORD_AW;

  logic [1:0] gnt, inflight_q, inflight_d, resp_now;

  // A port stays masked through its response cycle: req seen then is still the old one.
  tcm_rr_arbiter #(.PRIO_B_FIRST(PRIO_B_FIRST)) u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req_i  ({b_req, a_req}),
    .mask_i (inflight_q),
    .gnt_o  (gnt)
  );

  logic                       sel_b, any_gnt, req_wr, req_fault, mem_we, mem_re;
  logic [BYTE_ADDR_WIDTH-1:0] req_addr;
  logic [BUS_ACC_W-1:0]       req_acc;
  logic [WORD_AW-1:0]         word_idx;
  logic [3:0]                 byte_en;
  logic [31:0]                wdata_lane, mem_rd_word;

  always_comb begin
    sel_b      = gnt[TCM_PORT_B];
    any_gnt    = |gnt;
    req_addr   = sel_b ? b_addr : a_addr;
    req_acc    = sel_b ? b_acc  : a_acc;
    req_wr     = sel_b ? b_wr_b : a_wr_b;
    req_fault  = tcm_misaligned(req_acc, req_addr[1:0]) | (req_wr & ~sel_b);
    word_idx   = req_addr[BYTE_ADDR_WIDTH-1:2];
    byte_en    = tcm_byte_en(req_acc, req_addr[1:0]);
    wdata_lane = b_wdata << {req_addr[1:0], 3'b000};
    // rstn gate keeps a held request from writing while reset is asserted.
    mem_we     = any_gnt & req_wr & ~req_fault & rstn;
    mem_re     = any_gnt & ~req_wr & ~req_fault;
    inflight_d = (inflight_q & ~resp_now) | gnt;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (mem_we && byte_en[gi]) mem[word_idx] <= wdata_lane[gi*8 +: 8];
      if (mem_re)                rd_q          <= mem[word_idx];
    end
    assign mem_rd_word[gi*8 +: 8] = rd_q;
  end

  tcm_slot_t s1_q, s1_d;

  always_comb begin
    s1_d = '{valid: any_gnt, port: sel_b, fault: req_fault, wr: req_wr,
             acc: req_acc, lane: req_addr[1:0]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q       <= '0;
      inflight_q <= '0;
    end else begin
      s1_q       <= s1_d;
      inflight_q <= inflight_d;
    end
  end

  logic [31:0] rd_shift, r_data;
  logic        r_resp_a, r_resp_b;

  always_comb begin
    rd_shift = mem_rd_word >> {s1_q.lane, 3'b000};
    r_data   = mem_rd_word;
    if (s1_q.acc == BUS_ACC_W'(BUS_ACC_1B))      r_data = {24'd0, rd_shift[7:0]};
    else if (s1_q.acc == BUS_ACC_W'(BUS_ACC_2B)) r_data = {16'd0, rd_shift[15:0]};
    if (s1_q.fault || s1_q.wr) r_data = '0;
    r_resp_a = s1_q.valid & (s1_q.port == 1'(TCM_PORT_A));
    r_resp_b = s1_q.valid & (s1_q.port == 1'(TCM_PORT_B));
  end

  if (PIPE_OUT) begin : g_pipe
    logic        a_resp_q, a_fault_q, b_resp_q, b_fault_q;
    logic [31:0] a_rdata_q, b_rdata_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        a_resp_q  <= 1'b0;
        a_fault_q <= 1'b0;
        b_resp_q  <= 1'b0;
        b_fault_q <= 1'b0;
        a_rdata_q <= '0;
        b_rdata_q <= '0;
      end else begin
        a_resp_q  <= r_resp_a;
        a_fault_q <= r_resp_a & s1_q.fault;
        b_resp_q  <= r_resp_b;
        b_fault_q <= r_resp_b & s1_q.fault;
        if (r_resp_a) a_rdata_q <= r_data;
        if (r_resp_b) b_rdata_q <= r_data;
      end
    end
    assign a_resp   = a_resp_q;
    assign a_fault  = a_fault_q;
    assign a_rdata  = a_rdata_q;
    assign b_resp   = b_resp_q;
    assign b_fault  = b_fault_q;
    assign b_rdata  = b_rdata_q;
    assign resp_now = {b_resp_q, a_resp_q};
  end else begin : g_direct
    // Hold registers keep rdata stable between responses.
    logic [31:0] a_hold_q, b_hold_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        a_hold_q <= '0;
        b_hold_q <= '0;
      end else begin
        if (r_resp_a) a_hold_q <= r_data;
        if (r_resp_b) b_hold_q <= r_data;
      end
    end
    assign a_resp   = r_resp_a;
    assign a_fault  = r_resp_a & s1_q.fault;
    assign a_rdata  = r_resp_a ? r_data : a_hold_q;
    assign b_resp   = r_resp_b;
    assign b_fault  = r_resp_b & s1_q.fault;
    assign b_rdata  = r_resp_b ? r_data : b_hold_q;
    assign resp_now = {r_resp_b, r_resp_a};
  end

endmodule

// File: tb/tb_tcm_dual_controller.sv
// Bench for tcm_dual_controller: instance 0 without and instance 1 with the
// output pipeline stage; a scoreboard checks every response and its cycle.
module tb_tcm_dual_controller;

  localparam int AW = 12;

  typedef struct {
    int          d;
    int          p;
    bit          wr;
    logic [AW-1:0] addr;
    logic [1:0]  acc;
    logic [31:0] wdata;
    bit          fault;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          d;
    int          p;
    bit          fault;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic          a_req[2], a_wr_b[2], b_req[2], b_wr_b[2];
  logic [AW-1:0] a_addr[2], b_addr[2];
  logic [1:0]    a_acc[2], b_acc[2];
  logic [31:0]   b_wdata[2];
  logic          a_resp[2], a_fault[2], b_resp[2], b_fault[2];
  logic [31:0]   a_rdata[2], b_rdata[2];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t vt[32];
  int   nv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  tcm_dual_controller #(.BYTE_ADDR_WIDTH(AW), .PIPE_OUT(1'b0), .PRIO_B_FIRST(1'b1)) dut0 (
    .clk(clk), .rstn(rstn),
    .a_req(a_req[0]), .a_resp(a_resp[0]), .a_addr(a_addr[0]), .a_wr_b(a_wr_b[0]),
    .a_acc(a_acc[0]), .a_rdata(a_rdata[0]), .a_fault(a_fault[0]),
    .b_req(b_req[0]), .b_resp(b_resp[0]), .b_addr(b_addr[0]), .b_wr_b(b_wr_b[0]),
    .b_acc(b_acc[0]), .b_wdata(b_wdata[0]), .b_rdata(b_rdata[0]), .b_fault(b_fault[0])
  );

  tcm_dual_controller #(.BYTE_ADDR_WIDTH(AW), .PIPE_OUT(1'b1), .PRIO_B_FIRST(1'b1)) dut1 (
    .clk(clk), .rstn(rstn),
    .a_req(a_req[1]), .a_resp(a_resp[1]), .a_addr(a_addr[1]), .a_wr_b(a_wr_b[1]),
    .a_acc(a_acc[1]), .a_rdata(a_rdata[1]), .a_fault(a_fault[1]),
    .b_req(b_req[1]), .b_resp(b_resp[1]), .b_addr(b_addr[1]), .b_wr_b(b_wr_b[1]),
    .b_acc(b_acc[1]), .b_wdata(b_wdata[1]), .b_rdata(b_rdata[1]), .b_fault(b_fault[1])
  );

  function automatic logic get_resp(int d, int p);
    return (p != 0) ? b_resp[d] : a_resp[d];
  endfunction

  function automatic logic get_fault(int d, int p);
    return (p != 0) ? b_fault[d] : a_fault[d];
  endfunction

  function automatic logic [31:0] get_rdata(int d, int p);
    return (p != 0) ? b_rdata[d] : a_rdata[d];
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive(int d, int p, bit wr, logic [AW-1:0] addr, logic [1:0] acc,
                       logic [31:0] wdata, bit req);
    if (p == 0) begin
      a_req[d] = req; a_wr_b[d] = wr; a_addr[d] = addr; a_acc[d] = acc;
    end else begin
      b_req[d] = req; b_wr_b[d] = wr; b_addr[d] = addr; b_acc[d] = acc; b_wdata[d] = wdata;
    end
  endtask

  task automatic expect_resp(int d, int p, bit f, logic [31:0] rd, int due);
    exp_t e;
    e.d = d; e.p = p; e.fault = f; e.rdata = rd; e.due = due;
    sb.push_back(e);
  endtask

  task automatic wait_resp(int d, int p, output bit got);
    got = 1'b0;
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      got = get_resp(d, p);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL timeout: inst%0d port%0d got no resp, required one within 16 cycles", d, p);
    end
  endtask

  task automatic add_vec(int d, int p, bit wr, logic [AW-1:0] addr, logic [1:0] acc,
                         logic [31:0] wdata, bit f, logic [31:0] rd);
    vt[nv].d = d; vt[nv].p = p; vt[nv].wr = wr; vt[nv].addr = addr; vt[nv].acc = acc;
    vt[nv].wdata = wdata; vt[nv].fault = f; vt[nv].rdata = rd;
    nv++;
  endtask

  // Entered and left on a falling edge; issues one request and waits for it.
  task automatic run_vec(vec_t v);
    bit got;
    int lat;
    lat = (v.d == 0) ? 1 : 2;
    drive(v.d, v.p, v.wr, v.addr, v.acc, v.wdata, 1'b1);
    expect_resp(v.d, v.p, v.fault, v.rdata, cyc + lat);
    wait_resp(v.d, v.p, got);
    drive(v.d, v.p, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check("resp_fault_pulse", {30'd0, get_resp(v.d, v.p), get_fault(v.d, v.p)}, 32'd0);
    check("rdata_hold", get_rdata(v.d, v.p), v.rdata);
  endtask

  task automatic check_outputs_zero(int d);
    check("reset_flags", {28'd0, a_resp[d], a_fault[d], b_resp[d], b_fault[d]}, 32'd0);
    check("reset_rdata", a_rdata[d] | b_rdata[d], 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    logic        r, f;
    logic [31:0] rd;
    int          idx;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        r  = get_resp(d, p);
        f  = get_fault(d, p);
        rd = get_rdata(d, p);
        if (!r && f === 1'b1) begin
          tests++;
          fails++;
          $display("FAIL stray_fault: inst%0d port%0d fault=1 without resp, required 0", d, p);
        end
        if (r === 1'b1) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].d == d && sb[i].p == p) idx = i;
          tests++;
          if (idx < 0) begin
            fails++;
            $display("FAIL unexpected_resp: inst%0d port%0d resp=1 at cyc %0d, required none", d, p, cyc);
          end else begin
            $display("[TB] resp inst%0d port%s cyc=%0d fault=%0d rdata=%h", d, (p != 0) ? "B" : "A",
                     cyc, f, rd);
            if (f !== sb[idx].fault || rd !== sb[idx].rdata || cyc != sb[idx].due) begin
              fails++;
              $display("FAIL resp_check inst%0d port%0d: got fault=%0d rdata=%h cyc=%0d, required fault=%0d rdata=%h cyc=%0d",
                       d, p, f, rd, cyc, sb[idx].fault, sb[idx].rdata, sb[idx].due);
            end
            sb.delete(idx);
          end
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_resp inst%0d port%0d: got none by cyc %0d, required at cyc %0d",
                 sb[i].d, sb[i].p, cyc, sb[i].due);
        sb.delete(i);
      end
    end
  end

  initial begin
    int          k;
    bit          got;
    logic [31:0] words[4];

    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 1'b0, '0, '0, '0, 1'b0);
      drive(d, 1, 1'b0, '0, '0, '0, 1'b0);
    end

    // inst, port, wr, addr, acc, wdata, fault, rdata
    add_vec(0, 1, 1, 12'h010, 2'd2, 32'hDEADBEEF, 0, 32'h0);
    add_vec(0, 1, 0, 12'h011, 2'd0, 32'h0,        0, 32'h000000BE);
    add_vec(0, 1, 0, 12'h012, 2'd1, 32'h0,        0, 32'h0000DEAD);
    add_vec(0, 0, 0, 12'h010, 2'd2, 32'h0,        0, 32'hDEADBEEF);
    add_vec(0, 1, 1, 12'h020, 2'd2, 32'hAAAAAAAA, 0, 32'h0);
    add_vec(0, 1, 1, 12'h022, 2'd1, 32'h00001234, 0, 32'h0);
    add_vec(0, 0, 0, 12'h020, 2'd2, 32'h0,        0, 32'h1234AAAA);
    add_vec(0, 1, 1, 12'h021, 2'd0, 32'hFFFFFF55, 0, 32'h0);
    add_vec(0, 0, 0, 12'h020, 2'd2, 32'h0,        0, 32'h123455AA);
    add_vec(0, 0, 0, 12'h023, 2'd0, 32'h0,        0, 32'h00000012);
    add_vec(0, 1, 0, 12'h020, 2'd1, 32'h0,        0, 32'h000055AA);
    add_vec(0, 1, 1, 12'h000, 2'd2, 32'h11111111, 0, 32'h0);
    add_vec(0, 1, 1, 12'h004, 2'd2, 32'h22222222, 0, 32'h0);
    add_vec(0, 1, 1, 12'h008, 2'd2, 32'h33333333, 0, 32'h0);
    add_vec(0, 1, 1, 12'h00C, 2'd2, 32'h44444444, 0, 32'h0);
    add_vec(0, 1, 0, 12'h006, 2'd2, 32'h0,        1, 32'h0);
    add_vec(0, 0, 0, 12'h003, 2'd1, 32'h0,        1, 32'h0);
    add_vec(0, 0, 1, 12'h000, 2'd2, 32'hFFFFFFFF, 1, 32'h0);
    add_vec(0, 1, 0, 12'h000, 2'd3, 32'h0,        1, 32'h0);
    add_vec(0, 1, 1, 12'h001, 2'd1, 32'h0000FFFF, 1, 32'h0);
    add_vec(0, 1, 0, 12'h000, 2'd2, 32'h0,        0, 32'h11111111);
    add_vec(0, 1, 0, 12'h004, 2'd2, 32'h0,        0, 32'h22222222);
    add_vec(1, 1, 1, 12'h034, 2'd2, 32'h0BADF00D, 0, 32'h0);
    add_vec(1, 1, 1, 12'h040, 2'd2, 32'hCAFEF00D, 0, 32'h0);
    add_vec(1, 0, 0, 12'h043, 2'd0, 32'h0,        0, 32'h000000CA);
    add_vec(1, 1, 0, 12'h042, 2'd1, 32'h0,        0, 32'h0000CAFE);

    repeat (3) @(negedge clk);
    check_outputs_zero(0);
    check_outputs_zero(1);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < nv; i++) run_vec(vt[i]);

    // Reset lands while a pipelined write is in flight; a held write during reset must not land.
    drive(1, 1, 1'b1, 12'h030, 2'd2, 32'h77777777, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    drive(1, 1, 1'b1, 12'h034, 2'd2, 32'hFFFFFFFF, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero(1);
    end
    drive(1, 1, 1'b0, '0, '0, '0, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_resp_after_reset", {31'd0, b_resp[1]}, 32'd0);
    end

    // Both ports request continuously right after reset: B wins the first conflict.
    k = cyc;
    drive(1, 0, 1'b0, 12'h043, 2'd0, 32'h0, 1'b1);
    drive(1, 1, 1'b0, 12'h034, 2'd2, 32'h0, 1'b1);
    expect_resp(1, 1, 1'b0, 32'h0BADF00D, k + 2);
    expect_resp(1, 0, 1'b0, 32'h000000CA, k + 3);
    expect_resp(1, 1, 1'b0, 32'h0BADF00D, k + 5);
    expect_resp(1, 0, 1'b0, 32'h000000CA, k + 6);
    repeat (5) @(negedge clk);
    drive(1, 1, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    drive(1, 0, 1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);

    // Single-requester streaming on the unpipelined instance.
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    words[3] = 32'h44444444;
    k = cyc;
    drive(0, 0, 1'b0, 12'h000, 2'd2, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) expect_resp(0, 0, 1'b0, words[i], k + 1 + 2 * i);
    for (int i = 0; i < 4; i++) begin
      wait_resp(0, 0, got);
      if (i < 3) drive(0, 0, 1'b0, 12'(4 * (i + 1)), 2'd2, 32'h0, 1'b1);
      else       drive(0, 0, 1'b0, '0, '0, '0, 1'b0);
    end
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
